// File: rtl/dm_cfg_pkg.sv
// Shared types and constants for the driver-monitor configuration sequencer.
// The optional shadow-bank lock is enabled by defining DM_CFG_LOCK_EN.
package dm_cfg_pkg;

  localparam int NUM_REGS      = 6;
  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 4;
  localparam int DRAIN_CYCLES  = 4;
  localparam int SETTLE_CYCLES = 2;
  localparam int IDX_W         = $clog2(NUM_REGS);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CNT_W = $clog2(max3(DRAIN_CYCLES, NUM_REGS, SETTLE_CYCLES) + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WRITE,
    SETTLE
  } cfg_state_e;

  typedef enum int {
    CFG_W0       = 0,
    CFG_W1       = 1,
    CFG_W2       = 2,
    CFG_W3       = 3,
    CFG_WARN_TH  = 4,
    CFG_EMERG_TH = 5
  } cfg_addr_e;

  localparam logic [DATA_W-1:0] DEFAULT_CFG [NUM_REGS] =
    '{16'd2, 16'd3, 16'd1, 16'd4, 16'd100, 16'd180};

  localparam logic [ADDR_W-1:0] LOCK_ADDR = 4'hF;
  localparam logic [DATA_W-1:0] LOCK_KEY  = 16'hA5A5;

  function automatic logic is_lock_key(input logic [ADDR_W-1:0] addr,
                                       input logic [DATA_W-1:0] data);
    return (addr == LOCK_ADDR) && (data == LOCK_KEY);
  endfunction

endpackage

// File: rtl/dm_cfg_shadow_bank.sv
// Shadow copy of the monitor weights/thresholds, reset to the boot defaults.
// Threshold outputs bypass a same-cycle write so a commit checks the new value.
module dm_cfg_shadow_bank
  import dm_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [DATA_W-1:0] warn_th_o,
  output logic [DATA_W-1:0] emerg_th_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DEFAULT_CFG[i];
      end
    end else if (wr_en_i) begin
      regs_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o  = regs_q[rd_idx_i];
  assign warn_th_o  = (wr_en_i && (wr_idx_i == IDX_W'(CFG_WARN_TH)))  ? wr_data_i : regs_q[CFG_WARN_TH];
  assign emerg_th_o = (wr_en_i && (wr_idx_i == IDX_W'(CFG_EMERG_TH))) ? wr_data_i : regs_q[CFG_EMERG_TH];

endmodule

// File: rtl/dm_cfg_sequencer.sv
// Streams the shadow bank into the monitor after reset and on each host commit,
// holding monitor scoring meanwhile. Define DM_CFG_LOCK_EN for the write lock.
module dm_cfg_sequencer
  import dm_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_commit,
  output logic              host_ready,
  output logic              host_err,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] wght_data,
  output logic              mon_hold,
  output logic              cfg_done
);

  localparam logic [CNT_W-1:0]  DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WRITE_LAST  = CNT_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT  = ADDR_W'(NUM_REGS);

  cfg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_data_q;
  logic              idle;
  logic              shadow_we;
  logic              commit_ok;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] warn_th;
  logic [DATA_W-1:0] emerg_th;
`ifdef DM_CFG_LOCK_EN
  logic              lock_q, lock_d;
`endif

  dm_cfg_shadow_bank u_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (shadow_we),
    .wr_idx_i   (host_addr[IDX_W-1:0]),
    .wr_data_i  (host_data),
    .rd_idx_i   (IDX_W'(cnt_q)),
    .rd_data_o  (rd_data),
    .warn_th_o  (warn_th),
    .emerg_th_o (emerg_th)
  );

  assign idle      = (state_q == IDLE);
  assign commit_ok = (warn_th < emerg_th);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    shadow_we = 1'b0;
`ifdef DM_CFG_LOCK_EN
    lock_d    = lock_q;
`endif

    // Shadow writes only land in IDLE so a running stream never sees a torn bank.
    if (host_we) begin
      if (!idle) begin
        err_d = 1'b1;
`ifdef DM_CFG_LOCK_EN
      end else if (lock_q) begin
        err_d = 1'b1;
      end else if (is_lock_key(host_addr, host_data)) begin
        lock_d = 1'b1;
`endif
      end else if (host_addr >= ADDR_LIMIT) begin
        err_d = 1'b1;
      end else begin
        shadow_we = 1'b1;
      end
    end

    if (host_commit && !idle) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (host_commit || pend_q) begin
          pend_d = 1'b0;
          if (commit_ok) begin
            state_d = DRAIN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = WRITE;
          cnt_d   = CNT_W'(CFG_W0);
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WRITE_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset lands in DRAIN so every release is followed by a full boot load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DRAIN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
`ifdef DM_CFG_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef DM_CFG_LOCK_EN
      lock_q  <= lock_d;
`endif
      if (state_q == WRITE) begin
        last_addr_q <= ADDR_W'(cnt_q);
        last_data_q <= rd_data;
      end
    end
  end

  assign cfg_we     = !rst && (state_q == WRITE);
  assign host_ready = !rst && idle;
  assign mon_hold   = !rst && !idle;
  assign host_err   = !rst && err_q;
  assign cfg_done   = !rst && done_q;
  assign cfg_addr   = rst ? '0 : (cfg_we ? ADDR_W'(cnt_q) : last_addr_q);
  assign wght_data  = rst ? '0 : (cfg_we ? rd_data : last_data_q);

endmodule

// File: tb/tb_dm_cfg_sequencer.sv
// Self-checking bench for dm_cfg_sequencer: table of IDLE host operations plus
// hand-written boot, pending-commit, mid-stream reset and lock sequences.
module tb_dm_cfg_sequencer;

  localparam int D = 4;
  localparam int N = 6;
  localparam int S = 2;

  logic        clk;
  logic        rst;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [15:0] host_data;
  logic        host_commit;
  logic        host_ready;
  logic        host_err;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] wght_data;
  logic        mon_hold;
  logic        cfg_done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        commit;
    logic        expErr;
    logic        expStart;
  } vec_t;

  wr_t         expQ [$];
  wr_t         monExp;
  logic [15:0] model [6];
  logic        modelLock;
  vec_t        vecs [11];

  dm_cfg_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .host_commit (host_commit),
    .host_ready  (host_ready),
    .host_err    (host_err),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .wght_data   (wght_data),
    .mon_hold    (mon_hold),
    .cfg_done    (cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    model     = '{16'd2, 16'd3, 16'd1, 16'd4, 16'd100, 16'd180};
    modelLock = 1'b0;
  endtask

  task automatic modelWrite(input logic we, input logic [3:0] addr, input logic [15:0] data);
    if (we && addr < 4'd6 && !modelLock) model[addr[2:0]] = data;
  endtask

  task automatic pushStream();
    wr_t w;
    for (int i = 0; i < 6; i++) begin
      w.addr = 4'(i);
      w.data = model[i];
      expQ.push_back(w);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [15:0] data,
                               input logic commit);
    host_we     = we;
    host_addr   = addr;
    host_data   = data;
    host_commit = commit;
    step();
    host_we     = 1'b0;
    host_commit = 1'b0;
  endtask

  // Called at the first observation point after the sequence starts.
  task automatic checkSeqTiming(input string tag);
    logic expHold, expWe, expDone, expReady;
    for (int t = 1; t <= D + N + S + 2; t++) begin
      if (t > 1) step();
      expHold  = (t < 1 + D + N + S);
      expWe    = (t >= 1 + D) && (t <= D + N);
      expDone  = (t == 1 + D + N + S);
      expReady = (t >= 1 + D + N + S);
      checkOutput($sformatf("%s t%0d hold/we/done/ready", tag, t),
                  {mon_hold, cfg_we, cfg_done, host_ready},
                  {expHold, expWe, expDone, expReady});
      if (t == D + N + 2)
        checkOutput($sformatf("%s held addr/data", tag), {cfg_addr, wght_data}, {4'd5, model[5]});
    end
    checkOutput($sformatf("%s stream drained", tag), expQ.size(), 0);
  endtask

  // Scoreboard: every cfg_we cycle pops the oldest expected write.
  always begin
    @(posedge clk);
    #3;
    if (cfg_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected cfg_we", {31'd0, cfg_we}, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("stream addr/data", {cfg_addr, wght_data}, {monExp.addr, monExp.data});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ticks;

    vecs[0]  = '{1'b1, 4'd3, 16'd5,     1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd6, 16'd9,     1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'd4, 16'd200,   1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd0, 16'd0,     1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'd5, 16'd250,   1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd0, 16'd0,     1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 4'd4, 16'd250,   1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd4, 16'd249,   1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 4'd7, 16'd1,     1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 4'd0, 16'hFFFF,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 16'd0,     1'b1, 1'b0, 1'b1};

    rst = 1'b1; host_we = 1'b0; host_addr = '0; host_data = '0; host_commit = 1'b0;
    resetModel();

    // Boot load after reset release.
    repeat (3) step();
    checkOutput("reset outputs",
                {host_ready, host_err, cfg_we, mon_hold, cfg_done, cfg_addr, wght_data}, 0);
    pushStream();
    rst = 1'b0;
    #1;
    checkSeqTiming("boot");

    // Same-edge write and commit: stream uses the new value.
    modelWrite(1'b1, 4'd1, 16'd7);
    pushStream();
    applyStimulus(1'b1, 4'd1, 16'd7, 1'b1);
    checkOutput("bypass host_err", host_err, 0);
    checkSeqTiming("bypass");

    for (int i = 0; i < 11; i++) begin
      modelWrite(vecs[i].we, vecs[i].addr, vecs[i].data);
      if (vecs[i].expStart) pushStream();
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].commit);
      checkOutput($sformatf("vec%0d host_err", i), host_err, vecs[i].expErr);
      if (vecs[i].expStart) begin
        checkSeqTiming($sformatf("vec%0d", i));
      end else begin
        checkOutput($sformatf("vec%0d hold/ready", i), {mon_hold, host_ready}, 2'b01);
        step();
        checkOutput($sformatf("vec%0d err pulse end", i), host_err, 0);
      end
    end

    // Busy write rejected, two commits during WRITE merge into one pending run.
    pushStream();
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b1);
    host_we = 1'b1; host_addr = 4'd0; host_data = 16'h0055;
    step();
    host_we = 1'b0;
    checkOutput("busy write err", host_err, 1);
    step();
    checkOutput("busy write err pulse end", host_err, 0);
    step(); step();
    checkOutput("in write phase", cfg_we, 1);
    host_commit = 1'b1;
    step();
    host_commit = 1'b0;
    checkOutput("busy commit no err", host_err, 0);
    pushStream();
    host_commit = 1'b1;
    step();
    host_commit = 1'b0;
    step();
    checkOutput("second busy commit no err", host_err, 0);
    ticks = 8;
    while (cfg_done !== 1'b1 && ticks < 40) begin
      step();
      ticks++;
    end
    checkOutput("first done tick", ticks, 13);
    step();
    checkSeqTiming("pend");
    repeat (3) step();
    checkOutput("no third sequence", {mon_hold, host_ready}, 2'b01);

    // Reset in the third cfg_we cycle aborts the stream and reboots.
    pushStream();
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b1);
    repeat (6) step();
    checkOutput("third write visible", {cfg_we, cfg_addr}, {1'b1, 4'd2});
    @(negedge clk);
    rst = 1'b1;
    checkOutput("aborted writes left", expQ.size(), 3);
    expQ.delete();
    step();
    checkOutput("cfg_we after reset edge", cfg_we, 0);
    checkOutput("mid reset outputs",
                {host_ready, host_err, cfg_we, mon_hold, cfg_done, cfg_addr, wght_data}, 0);
    step(); step();
    resetModel();
    pushStream();
    rst = 1'b0;
    #1;
    checkSeqTiming("reboot");

`ifdef DM_CFG_LOCK_EN
    applyStimulus(1'b1, 4'hF, 16'hA5A5, 1'b0);
    checkOutput("lock key host_err", host_err, 0);
    modelLock = 1'b1;
    modelWrite(1'b1, 4'd2, 16'd9);
    applyStimulus(1'b1, 4'd2, 16'd9, 1'b0);
    checkOutput("locked write host_err", host_err, 1);
`else
    applyStimulus(1'b1, 4'hF, 16'hA5A5, 1'b0);
    checkOutput("addr F host_err", host_err, 1);
    modelWrite(1'b1, 4'd2, 16'd9);
    applyStimulus(1'b1, 4'd2, 16'd9, 1'b0);
    checkOutput("write after F host_err", host_err, 0);
`endif
    pushStream();
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b1);
    checkSeqTiming("lock");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
